// File: rtl/ppr_pkg.sv
// Shared constants for the partial-product reduction multiplier.
// Holds the default operand width, the reduction pass count and the FSM
// state encodings used by ppr_seq.
package ppr_pkg;

  // Default operand width in bits (must be even and at least 4)
  localparam int PPR_N = 8;

  // Number of RED passes: pass 0 folds rows 0..3, every later pass folds
  // two more rows into the running sum/carry pair
  localparam int PPR_K = (PPR_N - 2) / 2;

  // FSM state encodings, kept as plain constants for legacy tools
  typedef logic [1:0] ppr_state_t;
  localparam ppr_state_t ST_IDLE = 2'd0;
  localparam ppr_state_t ST_RED  = 2'd1;
  localparam ppr_state_t ST_ADD  = 2'd2;
  localparam ppr_state_t ST_DONE = 2'd3;

  // Pass count for an arbitrary operand width
  function automatic int pprPasses(input int n);
    return (n - 2) / 2;
  endfunction

  // Width of the pass counter; never narrower than one bit
  function automatic int pprCountWidth(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/ftc_row.sv
// Row of W four-to-two compressors built from two chained full adders per bit.
// The first adder's carry ripples only one position (into the next bit's
// second adder), so the row stays shallow regardless of width. Carries out of
// the top bit are dropped: the row computes in1+in2+in3+in4 mod 2^W as
// sum + carry.
module ftc_row #(
  parameter int W = 16
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] partial;
  logic [W-1:0] cin;

  assign cin[0]   = 1'b0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : gBit
    assign partial[i] = in1[i] ^ in2[i] ^ in3[i];
    assign sum[i]     = partial[i] ^ in4[i] ^ cin[i];

    // Top bit produces no outgoing carries: they would land beyond 2^W
    if (i < W - 1) begin : gUp
      assign cin[i+1]   = (in1[i] & in2[i]) | (in1[i] & in3[i]) | (in2[i] & in3[i]);
      assign carry[i+1] = (partial[i] & in4[i]) | (partial[i] & cin[i]) |
                          (in4[i] & cin[i]);
    end
  end

endmodule

// File: rtl/ppr_seq.sv
// Sequential unsigned multiplier. Operands are captured on acceptance, the N
// partial-product rows are folded into a sum/carry pair over K passes through
// one shared compressor row, a final add resolves the product, and the result
// is held until the consumer takes it.
module ppr_seq
  import ppr_pkg::*;
#(
  parameter int N = PPR_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int W  = 2 * N;
  localparam int K  = pprPasses(N);
  localparam int KW = pprCountWidth(K);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  ppr_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  product_q, product_d;

  logic [W-1:0]  pp [N];
  logic [W-1:0]  ppLo, ppHi;
  logic [W-1:0]  rowIn1, rowIn2;
  logic [W-1:0]  rowSum, rowCarry;

  // Partial-product rows from the captured operands, each pre-shifted
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pp[i] = b_q[i] ? (W'(a_q) << i) : '0;
    end
  end

  // Pick the two fresh rows this pass folds in: rows 2k+2 and 2k+3
  always_comb begin
    ppLo = '0;
    ppHi = '0;
    for (int i = 0; i < N; i++) begin
      if (i == 2 * int'(k_q) + 2) ppLo = pp[i];
      if (i == 2 * int'(k_q) + 3) ppHi = pp[i];
    end
  end

  // Pass 0 starts from rows 0 and 1; later passes recycle the running pair
  assign rowIn1 = (k_q == '0) ? pp[0] : s_q;
  assign rowIn2 = (k_q == '0) ? pp[1] : c_q;

  ftc_row #(.W(W)) uRow (
    .in1   (rowIn1),
    .in2   (rowIn2),
    .in3   (ppLo),
    .in4   (ppHi),
    .sum   (rowSum),
    .carry (rowCarry)
  );

  // Next-state and datapath control for IDLE -> RED x K -> ADD -> DONE
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    c_d       = c_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          state_d = ST_RED;
        end
      end
      ST_RED: begin
        s_d = rowSum;
        c_d = rowCarry;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_ADD;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_ADD: begin
        product_d = s_q + c_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      c_q       <= c_d;
      product_q <= product_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign product     = product_q;

endmodule

// File: tb/tb_ppr_seq.sv
// Directed bench for ppr_seq: latency and pulse width, stalled output,
// mid-operation reset, operand isolation and a randomized streaming run
// against a bench-side a*b reference.
module tb_ppr_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ppr_seq #(.N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One comparison: counts it and reports a miss with both values
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair at the current falling edge; returns at the
  // falling edge just after the acceptance edge
  task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn);
    a           = aIn;
    b           = bIn;
    start_valid = 1'b1;
    checkOutput("startReadyBeforeAccept", 32'(start_ready), 32'd1);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Count rising edges from acceptance until out_valid, bounded
  task automatic waitValid(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Full unstalled operation: latency, result, one-cycle pulse, back to idle
  task automatic runOp(input string tag, input logic [7:0] aIn,
                       input logic [7:0] bIn, input logic [15:0] exp);
    int edges;
    out_ready = 1'b1;
    applyStimulus(aIn, bIn);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    waitValid(edges);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd5);
    checkOutput({tag, "_product"}, 32'(product), 32'(exp));
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int edges;
    int seenValid;
    int sent;
    int recv;
    int cyc;
    logic [7:0]  nextA;
    logic [7:0]  nextB;
    logic [15:0] expQ [$];

    reset       = 1'b1;
    start_valid = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_outValid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_startReady", 32'(start_ready), 32'd1);
    checkOutput("rst_product", 32'(product), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed products including all-ones and zero multiplicand
    runOp("ffxff", 8'hFF, 8'hFF, 16'hFE01);
    runOp("a5x3c", 8'hA5, 8'h3C, 16'h26AC);
    runOp("00x7f", 8'h00, 8'h7F, 16'h0000);

    // Stalled consumer: product held, new offers ignored
    out_ready = 1'b0;
    applyStimulus(8'h0F, 8'h0D);
    waitValid(edges);
    checkOutput("stall_latency", 32'(edges), 32'd5);
    checkOutput("stall_product", 32'(product), 32'h00C3);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'b1;
      a           = 8'h55;
      b           = 8'h66;
      @(negedge clk);
      checkOutput($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall_hold%0d", i), 32'(product), 32'h00C3);
      checkOutput($sformatf("stall_ready%0d", i), 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_valid", 32'(out_valid), 32'd0);
    checkOutput("stall_release_idle", 32'(start_ready), 32'd1);
    checkOutput("stall_release_busy", 32'(busy), 32'd0);

    // Reset during RED pass 1
    applyStimulus(8'hC7, 8'h9E);
    @(negedge clk);
    checkOutput("midrst_busyBefore", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_outValid", 32'(out_valid), 32'd0);
    checkOutput("midrst_product", 32'(product), 32'd0);
    checkOutput("midrst_startReady", 32'(start_ready), 32'd1);
    @(negedge clk);
    reset     = 1'b0;
    seenValid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seenValid++;
    end
    checkOutput("midrst_noPulse", 32'(seenValid), 32'd0);
    runOp("12x34", 8'h12, 8'h34, 16'h03A8);

    // Operands wiggle while the operation is in flight
    out_ready = 1'b1;
    applyStimulus(8'h9B, 8'hD7);
    for (int i = 0; i < 4; i++) begin
      a           = 8'($urandom);
      b           = 8'($urandom);
      start_valid = 1'b1;
      @(negedge clk);
    end
    start_valid = 1'b0;
    checkOutput("isolate_valid", 32'(out_valid), 32'd1);
    checkOutput("isolate_product", 32'(product), 32'h822D);
    @(negedge clk);
    checkOutput("isolate_idle", 32'(start_ready), 32'd1);

    // Streaming run with random back-pressure and an in-order scoreboard
    sent  = 0;
    recv  = 0;
    cyc   = 0;
    nextA = 8'($urandom);
    nextB = 8'($urandom);
    while (recv < 256 && cyc < 20000) begin
      out_ready   = 1'($urandom_range(0, 1));
      start_valid = (sent < 256);
      a           = nextA;
      b           = nextB;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("stream_unexpected", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("stream%0d", recv), 32'(product),
                      32'(expQ.pop_front()));
        end
        recv++;
      end
      if (start_valid && start_ready) begin
        expQ.push_back(16'(nextA) * 16'(nextB));
        sent++;
        nextA = 8'($urandom);
        nextB = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start_valid = 1'b0;
    out_ready   = 1'b1;
    checkOutput("stream_count", 32'(recv), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
